regfile_wb_controller: RTL
==========================

# regfile_wb_controller

Writeback controller for the integer register file: arbitrates its single write port between the execute-stage and memory-stage writeback sources, and keeps a per-register pending-write scoreboard the issue stage queries for RAW/WAW hazards. Sits between the execute/memory stages and the register file write port; the issue stage talks to it through an allocate handshake and two busy-query ports.

## Interface
- xlen, 64, data width of the register file and writeback data
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  synchronous, active-low reset
- alloc_valid  input  1  issue stage claims a destination register
- alloc_rd  input  5  destination register being claimed
- alloc_ready  output  1  claim accepted this cycle (combinational)
- rs1, rs2  input  5  source registers queried by the issue stage
- rs1_busy, rs2_busy  output  1  queried register has a pending write (combinational from scoreboard)
- ex_valid  input  1  execute writeback request
- ex_rd  input  5  execute destination
- ex_data  input  xlen  execute result
- ex_ready  output  1  execute request granted this cycle (combinational)
- mem_valid, mem_rd, mem_data, mem_ready  same as ex_*, memory/load source
- rf_write_en  output  1  register file write enable (registered)
- rf_rd  output  5  register file write address (registered)
- rf_rd_data  output  xlen  register file write data (registered)
- pending_count  output  6  number of busy bits set (registered, 0..31)

## Operation
- Scoreboard: 32 busy bits; busy[0] constant 0. rsN_busy = busy[rsN].
- Allocate: alloc_ready = alloc_valid && (alloc_rd == 0 || !busy[alloc_rd]). On alloc_valid && alloc_ready with alloc_rd != 0, busy[alloc_rd] set at the clock edge. alloc_rd == 0 is accepted with no state change. A WAW claim on a busy register stalls (alloc_ready = 0) until that bit clears; a clear in the same cycle does not unblock it.
- Arbitration: one-bit round-robin pointer, reset value = ex. Only ex valid: grant ex. Only mem valid: grant mem. Both valid: grant the pointer holder. After every grant the pointer moves to the non-granted source. At most one of ex_ready/mem_ready high per cycle; ready is never high without the matching valid.
- Grant capture: granted source's rd and data registered into rf_rd/rf_rd_data; rf_write_en = 1 if granted rd != 0, else 0 (handshake still completes). No grant: rf_write_en = 0, rf_rd/rf_rd_data hold.
- Commit: in the cycle rf_write_en = 1, busy[rf_rd] clears at the clock edge ending that cycle (same edge the register file writes).
- Simultaneous set and clear of the same register in one cycle: set wins, bit stays 1.
- Writeback to a register not marked busy is legal; the write happens and the bit stays 0.
- pending_count updated each edge to popcount of next busy vector.

## Timing
- Reset (rstn low at an edge): busy all 0, pointer = ex, rf_write_en 0, rf_rd 0, rf_rd_data 0, pending_count 0. While rstn is low alloc_ready, ex_ready, mem_ready are 0. A grant registered before reset is discarded; no write issues after reset.
- Grant in cycle N -> rf_write_en/rf_rd/rf_rd_data valid in cycle N+1 -> register file updated and busy cleared at end of N+1; from cycle N+2 the register reads new data with busy = 0.
- Allocate in cycle N -> rsN_busy high from cycle N+1.
- Back-to-back grants sustain one write per cycle; a non-granted source holds valid/rd/data until ready.
- pending_count lags busy by zero cycles (both registered at the same edge).

## Test plan
- Reset: assert rstn=0 one cycle mid-stream with ex_valid pending -> all outputs 0, pointer = ex, no rf_write_en in the following cycle, pending_count 0.
- Single path: alloc x5, then ex_valid rd=5 data=0xDEAD in cycle N -> ex_ready=1 in N, rf_write_en=1 rf_rd=5 rf_rd_data=0xDEAD in N+1, rs1=5 busy 1 through N+1 and 0 from N+2.
- Contention: ex and mem valid every cycle for 4 cycles (rd 1..4 each) -> grants ex, mem, ex, mem; pointer ends at ex; exactly one ready per cycle.
- WAW stall: alloc x7, then alloc x7 again -> second alloc_ready=0 until cycle after x7 commit, then 1; pending_count 1 throughout.
- Set/clear collision: x9 committing in same cycle as new alloc x9 -> busy[9] remains 1, pending_count unchanged.
- x0: alloc x0 and mem_valid rd=0 data=0xFFFF -> alloc_ready=1, mem_ready=1, rf_write_en=0, rs1=0 busy always 0, pending_count 0.

Source files
------------

// File: rtl/regfile_wb_controller.sv
// -----------------------------------------------------------------------------
// regfile_wb_controller
//
// Writeback controller for the integer register file. It shares the single
// register-file write port between the execute and memory writeback sources
// using a one-bit round-robin arbiter. It also keeps a 32-entry pending-write
// scoreboard that the issue stage uses to detect RAW and WAW hazards.
//
// Ports
//   clk, rstn                     clock; synchronous active-low reset
//   alloc_valid/alloc_rd          issue stage claims a destination register
//   alloc_ready                   claim accepted this cycle (combinational)
//   rs1/rs2 -> rs1_busy/rs2_busy  scoreboard lookups (combinational)
//   ex_valid/ex_rd/ex_data        execute writeback request
//   ex_ready                      execute grant (combinational)
//   mem_valid/mem_rd/mem_data     memory writeback request
//   mem_ready                     memory grant (combinational)
//   rf_write_en/rf_rd/rf_rd_data  registered register-file write port
//   pending_count                 registered popcount of the scoreboard
// -----------------------------------------------------------------------------
module regfile_wb_controller #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            alloc_valid,
    input  logic [4:0]      alloc_rd,
    output logic            alloc_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    output logic            ex_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rf_write_en,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_rd_data,
    output logic [5:0]      pending_count
);

    // Round-robin pointer: the source that wins when both are valid.
    typedef enum logic {PTR_EX = 1'b0, PTR_MEM = 1'b1} ptr_e;

    ptr_e            ptr_q, ptr_d;
    logic [31:0]     busy_q, busy_d;
    logic            we_q, we_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            ex_gnt, mem_gnt, alloc_ok;

    always_comb begin
        // Grant and claim handshakes are suppressed while reset is held.
        ex_gnt   = rstn && ex_valid  && (!mem_valid || ptr_q == PTR_EX);
        mem_gnt  = rstn && mem_valid && (!ex_valid  || ptr_q == PTR_MEM);
        // A WAW check uses the registered busy bit, so a commit in the
        // same cycle does not unblock the claim.
        alloc_ok = rstn && alloc_valid && (alloc_rd == 5'd0 || !busy_q[alloc_rd]);

        // The clear is applied first so that a same-cycle set wins.
        busy_d = busy_q;
        if (we_q)     busy_d[rd_q]     = 1'b0;
        if (alloc_ok) busy_d[alloc_rd] = 1'b1;
        busy_d[0] = 1'b0;

        cnt_d = 6'd0;
        for (int i = 1; i < 32; i++) cnt_d = cnt_d + {5'd0, busy_d[i]};

        // With no grant, the address and data hold their previous values.
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (ex_gnt) begin
            ptr_d  = PTR_MEM;
            we_d   = (ex_rd != 5'd0);
            rd_d   = ex_rd;
            data_d = ex_data;
        end else if (mem_gnt) begin
            ptr_d  = PTR_EX;
            we_d   = (mem_rd != 5'd0);
            rd_d   = mem_rd;
            data_d = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q  <= PTR_EX;
            busy_q <= '0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign alloc_ready   = alloc_ok;
    assign ex_ready      = ex_gnt;
    assign mem_ready     = mem_gnt;
    assign rs1_busy      = busy_q[rs1];
    assign rs2_busy      = busy_q[rs2];
    assign rf_write_en   = we_q;
    assign rf_rd         = rd_q;
    assign rf_rd_data    = data_q;
    assign pending_count = cnt_q;

endmodule
